sp_traceback_ctrl: RTL

Controller for the 32×64-bit survivor-path memory of the K=7 (64-state) Viterbi decoder. It owns the memory's single address/write port and shares it between the ACS unit, which writes one 64-bit decision vector per trellis step, and an internal traceback engine. Every 8 written vectors, once the buffer is primed, it traces back 16 steps from the ACS best state and emits 8 decoded bits, oldest first.

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/sp_traceback_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and FSM encoding for the K=7 Viterbi survivor-path
// memory and its traceback controller.
package viterbi_pkg;

    localparam int DEPTH    = 32;
    localparam int ADDR_W   = 5;
    localparam int DEC_W    = 64;
    localparam int STATE_W  = 6;
    localparam int TB_CONV  = 8;
    localparam int TB_OUT   = 8;
    localparam int TB_STEPS = TB_CONV + TB_OUT;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        EVAL,
        OUT
    } tb_fsm_e;

endpackage

// File: rtl/sp_traceback_ctrl.sv
// Survivor-path memory controller: shares the single memory port between ACS
// decision writes and a 16-step traceback that emits 8 decoded bits per job.
module sp_traceback_ctrl
    import viterbi_pkg::*;
(
    input  logic               clk,
    input  logic               RST,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [DEC_W-1:0]   dec_i,
    input  logic [STATE_W-1:0] start_state,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DEC_W-1:0]   mem_din,
    input  logic [DEC_W-1:0]   mem_q,
    output logic               bit_valid,
    output logic               bit_o,
    output logic               busy
);

    tb_fsm_e            state;
    logic [ADDR_W-1:0]  wptr;
    logic [ADDR_W-1:0]  top;
    logic [2:0]         wcnt;
    logic               primed;
    logic [3:0]         k;
    logic [STATE_W-1:0] tb_state;
    logic [TB_OUT-1:0]  out_sr;

    logic               wcnt_last;
    logic               accept;
    logic               launch;
    logic               dec_bit;
    logic [ADDR_W-1:0]  rd_addr;

    // The 8th write of a window is held off while a job runs, so a launch
    // can never land on top of an active traceback.
    assign wcnt_last = (wcnt == 3'd7);
    assign dec_ready = !RST && !(wcnt_last && primed && state != IDLE);
    assign accept    = dec_valid && dec_ready;
    assign launch    = accept && wcnt_last && primed;

    assign rd_addr   = (state == RD && !RST) ? top - ADDR_W'(k) : '0;
    assign mem_wr    = accept;
    assign mem_din   = dec_i;
    assign mem_addr  = accept ? wptr : rd_addr;

    assign dec_bit   = mem_q[tb_state];

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= IDLE;
            wptr      <= '0;
            wcnt      <= '0;
            primed    <= 1'b0;
            top       <= '0;
            k         <= '0;
            tb_state  <= '0;
            out_sr    <= '0;
            bit_valid <= 1'b0;
            bit_o     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                wptr <= wptr + ADDR_W'(1);
                wcnt <= wcnt + 3'd1;
                if (wcnt_last)
                    primed <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (launch) begin
                        top      <= wptr;
                        tb_state <= start_state;
                        k        <= '0;
                        busy     <= 1'b1;
                        state    <= RD;
                    end
                end
                // A write owns the port this cycle; retry the read next cycle.
                RD: begin
                    if (!accept)
                        state <= EVAL;
                end
                EVAL: begin
                    tb_state <= {tb_state[STATE_W-2:0], dec_bit};
                    if (k >= 4'(TB_CONV))
                        out_sr <= {out_sr[TB_OUT-2:0], tb_state[STATE_W-1]};
                    k <= k + 4'd1;
                    if (k == 4'(TB_STEPS - 1)) begin
                        // Last step is the oldest bit: present it on entry to OUT.
                        bit_valid <= 1'b1;
                        bit_o     <= tb_state[STATE_W-1];
                        state     <= OUT;
                    end else begin
                        state <= RD;
                    end
                end
                OUT: begin
                    out_sr <= out_sr >> 1;
                    k      <= k + 4'd1;
                    if (k[2:0] == 3'(TB_OUT - 1)) begin
                        bit_valid <= 1'b0;
                        bit_o     <= 1'b0;
                        busy      <= 1'b0;
                        k         <= '0;
                        state     <= IDLE;
                    end else begin
                        bit_o <= out_sr[1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
